// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA read buffer.
//   DATA_W       pixel width (RGB565)
//   FIFO_AW      FIFO address width, depth = 2**FIFO_AW
//   BURST_LEN    pixels per frame-buffer read burst
//   FRAME_PIXELS active pixels per frame (1024 x 720)
//   ADDR_W       pixel address width
package vga_pkg;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned FIFO_AW      = 9;
  localparam int unsigned BURST_LEN    = 128;
  localparam int unsigned FRAME_PIXELS = 737280;
  localparam int unsigned ADDR_W       = 20;

  localparam logic [DATA_W-1:0] BLANK_PIXEL = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRecv,
    StDrain
  } rd_state_e;

endpackage

// File: rtl/vga_rd_buffer_if.sv
// Frame-buffer burst read port.
//   fb_rd_req   burst request, held until fb_rd_ack
//   fb_rd_addr  pixel address of the requested burst
//   fb_rd_ack   one-cycle acceptance of the request
//   fb_rd_vld   returned pixel beat valid
//   fb_rd_data  returned pixel
// master: the buffer issuing requests; slave: the frame-buffer side.
interface vga_rd_buffer_if
  import vga_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned AddrW = ADDR_W
) ();

  logic             fb_rd_req;
  logic [AddrW-1:0] fb_rd_addr;
  logic             fb_rd_ack;
  logic             fb_rd_vld;
  logic [DataW-1:0] fb_rd_data;

  modport master (
    output fb_rd_req,
    output fb_rd_addr,
    input  fb_rd_ack,
    input  fb_rd_vld,
    input  fb_rd_data
  );

  modport slave (
    input  fb_rd_req,
    input  fb_rd_addr,
    output fb_rd_ack,
    output fb_rd_vld,
    output fb_rd_data
  );

endinterface

// File: rtl/vga_buf_ram.sv
// Simple dual-port pixel RAM, 2**AddrW x DataW.
//   sclk     clock for both ports
//   s_rst    synchronous reset of the read output register
//   wr_en/wr_addr/wr_data  synchronous write port
//   rd_en/rd_addr          synchronous read port
//   rd_data  registered read data; blank when no read was issued last cycle
module vga_buf_ram
  import vga_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned AddrW = FIFO_AW
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [DataW-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic [DataW-1:0] rd_data
);

  logic [DataW-1:0] mem [0:(1 << AddrW) - 1];

  always_ff @(posedge sclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rd_data <= BLANK_PIXEL;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= BLANK_PIXEL;
    end
  end

endmodule

// File: rtl/vga_rd_buffer.sv
// Pixel buffer between the frame-buffer read port and the VGA timing driver.
//   sclk, s_rst   clock and synchronous active-high reset
//   frame_start   per-frame pulse: flush FIFO, restart address, clear flags
//   fb            frame-buffer burst read port (master side)
//   data_req      pixel pop request; img_data follows one cycle later
//   img_data      popped pixel, or blank
//   fifo_level    FIFO occupancy
//   underflow     sticky: pop requested while empty
//   overflow      sticky: beat arrived while full
module vga_rd_buffer
  import vga_pkg::*;
#(
  parameter int unsigned DataW       = DATA_W,
  parameter int unsigned FifoAw      = FIFO_AW,
  parameter int unsigned BurstLen    = BURST_LEN,
  parameter int unsigned FramePixels = FRAME_PIXELS,
  parameter int unsigned AddrW       = ADDR_W
) (
  input  logic               sclk,
  input  logic               s_rst,
  input  logic               frame_start,
  vga_rd_buffer_if.master    fb,
  input  logic               data_req,
  output logic [DataW-1:0]   img_data,
  output logic [FifoAw:0]    fifo_level,
  output logic               underflow,
  output logic               overflow
);

  localparam int unsigned Depth = 1 << FifoAw;
  localparam int unsigned LvlW  = FifoAw + 1;
  localparam int unsigned CntW  = $clog2(BurstLen) + 1;

  rd_state_e         state_q, state_d;
  logic [FifoAw-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic [CntW-1:0]   out_q, out_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic              underflow_q, overflow_q;

  logic              full, empty, push, pop;
  logic [LvlW:0]     credit;
  logic [AddrW:0]    addr_inc;
  logic [AddrW-1:0]  addr_next;

  assign full  = (level_q == LvlW'(Depth));
  assign empty = (level_q == '0);
  // Beats returning after a frame_start belong to the old frame and are dropped.
  assign push  = fb.fb_rd_vld && !full && (state_q != StDrain) && !frame_start;
  assign pop   = data_req && !empty && !frame_start;

  assign credit    = {1'b0, level_q} + (LvlW + 1)'(out_q);
  assign addr_inc  = {1'b0, addr_q} + (AddrW + 1)'(BurstLen);
  assign addr_next = (addr_inc >= (AddrW + 1)'(FramePixels)) ? '0 : addr_inc[AddrW-1:0];

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (frame_start) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FifoAw'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FifoAw'(1);
      level_q <= level_d;
      if (fb.fb_rd_vld && full) overflow_q  <= 1'b1;
      if (data_req && empty)    underflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (!frame_start && (credit <= (LvlW + 1)'(Depth - BurstLen))) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (fb.fb_rd_ack) begin
          // An ack coinciding with frame_start still commits the burst.
          out_d   = CntW'(BurstLen);
          addr_d  = addr_next;
          state_d = frame_start ? StDrain : StRecv;
        end else if (frame_start) begin
          state_d = StIdle;
        end
      end
      StRecv, StDrain: begin
        if (fb.fb_rd_vld && (out_q != '0)) begin
          out_d = out_q - CntW'(1);
        end
        if (out_d == '0) begin
          state_d = StIdle;
        end else if (frame_start) begin
          state_d = StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
    if (frame_start) begin
      addr_d = '0;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
    end
  end

  vga_buf_ram #(
    .DataW (DataW),
    .AddrW (FifoAw)
  ) u_ram (
    .sclk    (sclk),
    .s_rst   (s_rst),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (fb.fb_rd_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr_q),
    .rd_data (img_data)
  );

  assign fb.fb_rd_req  = (state_q == StReq);
  assign fb.fb_rd_addr = addr_q;
  assign fifo_level    = level_q;
  assign underflow     = underflow_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_vga_rd_buffer.sv
// Directed bench for vga_rd_buffer. A second instance with a 512-pixel frame
// shares all stimulus so the address wrap is reached in a few bursts.
module tb_vga_rd_buffer;

  logic        sclk = 1'b0;
  logic        s_rst;
  logic        frame_start;
  logic        data_req;
  logic [15:0] img_a, img_b;
  logic [9:0]  level_a, level_b;
  logic        uf_a, uf_b, of_a, of_b;

  int checks = 0;
  int errors = 0;

  vga_rd_buffer_if fb_a ();
  vga_rd_buffer_if fb_b ();

  vga_rd_buffer u_dut (
    .sclk        (sclk),
    .s_rst       (s_rst),
    .frame_start (frame_start),
    .fb          (fb_a),
    .data_req    (data_req),
    .img_data    (img_a),
    .fifo_level  (level_a),
    .underflow   (uf_a),
    .overflow    (of_a)
  );

  vga_rd_buffer #(
    .FramePixels (512)
  ) u_dut_wrap (
    .sclk        (sclk),
    .s_rst       (s_rst),
    .frame_start (frame_start),
    .fb          (fb_b),
    .data_req    (data_req),
    .img_data    (img_b),
    .fifo_level  (level_b),
    .underflow   (uf_b),
    .overflow    (of_b)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fb_drive(input logic ack, input logic vld, input logic [15:0] d);
    fb_a.fb_rd_ack  = ack;
    fb_a.fb_rd_vld  = vld;
    fb_a.fb_rd_data = d;
    fb_b.fb_rd_ack  = ack;
    fb_b.fb_rd_vld  = vld;
    fb_b.fb_rd_data = d;
  endtask

  // Wait (bounded) for a request, ack it, and return 128 ramp beats.
  task automatic do_burst(input logic [19:0] addr, input logic [15:0] base);
    for (int i = 0; i < 8 && !fb_a.fb_rd_req; i++) tick();
    check("burst_req", 32'(fb_a.fb_rd_req), 32'd1);
    check("burst_addr", 32'(fb_a.fb_rd_addr), 32'(addr));
    check("burst_addr_wrapinst", 32'(fb_b.fb_rd_addr), 32'(addr));
    fb_drive(1'b1, 1'b0, 16'h0);
    tick();
    fb_drive(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 128; i++) begin
      fb_drive(1'b0, 1'b1, base + 16'(i));
      tick();
    end
    fb_drive(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    s_rst       = 1'b1;
    frame_start = 1'b0;
    data_req    = 1'b0;
    fb_drive(1'b0, 1'b0, 16'h0);
    tick();
    tick();
    check("rst_req", 32'(fb_a.fb_rd_req), 32'd0);
    check("rst_addr", 32'(fb_a.fb_rd_addr), 32'd0);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_img", 32'(img_a), 32'd0);
    check("rst_uf", 32'(uf_a), 32'd0);
    check("rst_of", 32'(of_a), 32'd0);
    s_rst = 1'b0;

    // Prefill: four bursts, then no fifth request at level 512.
    do_burst(20'd0,   16'd0);
    do_burst(20'd128, 16'd128);
    do_burst(20'd256, 16'd256);
    do_burst(20'd384, 16'd384);
    tick();
    tick();
    tick();
    check("prefill_level", 32'(level_a), 32'd512);
    check("prefill_no_req", 32'(fb_a.fb_rd_req), 32'd0);
    check("prefill_addr", 32'(fb_a.fb_rd_addr), 32'd512);
    check("wrap_addr_small", 32'(fb_b.fb_rd_addr), 32'd0);

    // Latency: three pops, then blank.
    data_req = 1'b1;
    tick();
    check("lat_img0", 32'(img_a), 32'd0);
    tick();
    check("lat_img1", 32'(img_a), 32'd1);
    tick();
    check("lat_img2", 32'(img_a), 32'd2);
    data_req = 1'b0;
    tick();
    check("lat_blank", 32'(img_a), 32'd0);
    check("lat_level", 32'(level_a), 32'd509);

    // Drain to 256 (a request is raised and left pending).
    data_req = 1'b1;
    for (int i = 0; i < 253; i++) begin
      tick();
      check("drain_img", 32'(img_a), 32'(3 + i));
    end
    check("drain_level", 32'(level_a), 32'd256);

    // Simultaneous push and pop at level 256.
    for (int i = 0; i < 100; i++) begin
      fb_drive(1'b0, 1'b1, 16'h1000 + 16'(i));
      tick();
      check("pp_img", 32'(img_a), 32'(256 + i));
      check("pp_level", 32'(level_a), 32'd256);
    end
    fb_drive(1'b0, 1'b0, 16'h0);
    data_req = 1'b0;
    tick();
    check("pp_blank", 32'(img_a), 32'd0);
    check("pp_of", 32'(of_a), 32'd0);
    check("pend_req", 32'(fb_a.fb_rd_req), 32'd1);
    check("pend_addr", 32'(fb_a.fb_rd_addr), 32'd512);
    check("pend_addr_wrap", 32'(fb_b.fb_rd_addr), 32'd0);

    // Mid-burst frame_start after 40 of 128 beats.
    fb_drive(1'b1, 1'b0, 16'h0);
    tick();
    fb_drive(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 40; i++) begin
      fb_drive(1'b0, 1'b1, 16'h2000 + 16'(i));
      tick();
    end
    fb_drive(1'b0, 1'b0, 16'h0);
    check("mid_level", 32'(level_a), 32'd296);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("fs_level", 32'(level_a), 32'd0);
    check("fs_req", 32'(fb_a.fb_rd_req), 32'd0);
    for (int i = 0; i < 88; i++) begin
      fb_drive(1'b0, 1'b1, 16'h3000 + 16'(i));
      tick();
      check("dr_level", 32'(level_a), 32'd0);
      check("dr_req", 32'(fb_a.fb_rd_req), 32'd0);
    end
    fb_drive(1'b0, 1'b0, 16'h0);
    tick();
    check("post_dr_req", 32'(fb_a.fb_rd_req), 32'd1);
    check("post_dr_addr", 32'(fb_a.fb_rd_addr), 32'd0);

    // Underflow: pop on empty FIFO, sticky until frame_start.
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    check("uf_img", 32'(img_a), 32'd0);
    check("uf_set", 32'(uf_a), 32'd1);
    tick();
    check("uf_sticky", 32'(uf_a), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("uf_clr", 32'(uf_a), 32'd0);
    check("fs_drop_req", 32'(fb_a.fb_rd_req), 32'd0);

    // Overflow: refill, then one beat while full.
    do_burst(20'd0,   16'd0);
    do_burst(20'd128, 16'd128);
    do_burst(20'd256, 16'd256);
    do_burst(20'd384, 16'd384);
    fb_drive(1'b0, 1'b1, 16'hBEEF);
    tick();
    fb_drive(1'b0, 1'b0, 16'h0);
    check("of_set", 32'(of_a), 32'd1);
    check("of_level", 32'(level_a), 32'd512);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("of_clr", 32'(of_a), 32'd0);
    check("of_flush", 32'(level_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rd_buffer.md
Name: vga_rd_buffer

Overview:
- Single-clock pixel buffer directly upstream of the VGA timing driver.
- Fetches RGB565 pixels from the frame-buffer read port in fixed-length bursts and stores them in an internal FIFO.
- Serves the driver's data_req strobe with img_data exactly one cycle later.
- Regenerates the frame-buffer read address every frame and flags underflow/overflow.

Parameters:
- DATA_W, 16, pixel width (RGB565).
- FIFO_AW, 9, FIFO address width; depth = 2^FIFO_AW = 512 pixels.
- BURST_LEN, 128, pixels per frame-buffer read burst; power of two, < depth.
- FRAME_PIXELS, 737280, active pixels per frame (1024 x 720).
- ADDR_W, 20, pixel address width.

Ports:
- sclk  in  1  system clock; all logic on its rising edge.
- s_rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per frame, before the first data_req.
- fb_rd_req  out  1  burst read request, held high until acknowledged.
- fb_rd_addr  out  ADDR_W  pixel address of the requested burst; stable while fb_rd_req=1.
- fb_rd_ack  in  1  one-cycle acceptance of the current request.
- fb_rd_vld  in  1  returned pixel beat valid.
- fb_rd_data  in  DATA_W  returned pixel.
- data_req  in  1  pixel pop request from the VGA driver.
- img_data  out  DATA_W  pixel for the data_req of the previous cycle.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- underflow  out  1  sticky: data_req seen while the FIFO was empty.
- overflow  out  1  sticky: fb_rd_vld seen while the FIFO was full.

Behaviour:
- Reset (s_rst=1 at a clock edge) forces the following; reset wins over every other input in that cycle.
  - All outputs 0.
  - FIFO empty; pointers 0.
  - FSM in IDLE; address counter 0.
- FIFO write: on fb_rd_vld=1 and not full, push fb_rd_data.
  - When full, drop the beat and set overflow.
- FIFO read: on data_req=1 and not empty, pop the head; img_data takes the head value on the next edge (1-cycle latency).
  - When empty, no pop; img_data = 16'h0000 next cycle; set underflow.
  - In any cycle after data_req=0, img_data = 16'h0000.
- Simultaneous push and pop: fifo_level is unchanged. Pointers wrap modulo depth. The full/empty decision uses the extra level bit.
- Credit: outstanding = beats requested but not yet received (0..BURST_LEN).
- FSM states:
  - IDLE: if fifo_level + outstanding <= depth - BURST_LEN, go to REQ.
  - REQ: fb_rd_req=1. When fb_rd_ack=1, set outstanding = BURST_LEN and go to RECV. Advance the address by BURST_LEN; if the result >= FRAME_PIXELS, wrap to 0.
  - RECV: decrement outstanding on each fb_rd_vld. Return to IDLE in the cycle after the last beat.
  - DRAIN: discard fb_rd_vld beats (no push) until outstanding = 0, then go to IDLE.
- frame_start (when not in reset):
  - Flush the FIFO (level 0) and set the address counter to 0.
  - Clear underflow and overflow.
  - Ignore wr/rd in that cycle.
  - FSM transitions:
    - From RECV with outstanding > 0: go to DRAIN.
    - From REQ: drop the request (fb_rd_req=0 next cycle) and go to IDLE. An fb_rd_ack arriving in that same cycle counts as accepted: go to DRAIN with outstanding = BURST_LEN.
    - From IDLE or DRAIN: stay in the same state.
- Frame-buffer ordering: beats return in address order. fb_rd_vld is never asserted in IDLE or REQ; if it is, the beat is pushed normally and outstanding does not go below 0.
- Address arithmetic is unsigned, ADDR_W bits. FRAME_PIXELS must be a multiple of BURST_LEN.

Decomposition:
- Shared package vga_pkg:
  - Constants DATA_W, FRAME_PIXELS, BURST_LEN.
  - FSM state encoding (IDLE, REQ, RECV, DRAIN) as localparams.
  - The pixel constant BLANK_PIXEL = 16'h0000.
- Sub-module vga_buf_ram: simple dual-port RAM, 2^FIFO_AW x DATA_W. One synchronous write port and one synchronous read port (1-cycle read latency), both on sclk. The read output is registered, giving the img_data latency.
- Pointer, level, FSM and address logic stay in vga_rd_buffer.

Test Plan:
- Prefill: reset, then ack each request immediately and return 128 beats of ramp data 0..127. Expect:
  - Requests continue until level = 512: 4 bursts at addresses 0, 128, 256, 384.
  - No fifth request while level + outstanding > 384.
- Latency: with FIFO holding 0..511, pulse data_req for 3 cycles. Expect img_data = 0, 1, 2 on the three following cycles, then 16'h0000; level = 509.
- Underflow: with FIFO empty, assert data_req once. Expect img_data = 0, underflow=1 (sticky); frame_start clears it.
- Address wrap: run a full frame of 5760 bursts. Expect the last fb_rd_addr = 737152, the next = 0.
- Mid-burst frame_start: after 40 of 128 beats, pulse frame_start. Expect:
  - Level 0 next cycle; remaining 88 beats discarded (level stays 0).
  - Next request at address 0, issued only after the 88th discarded beat.
- Simultaneous push/pop at level 256 for 100 cycles: level stays 256, data order preserved, overflow=0.
